pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the IF/ID and ID/EX pipeline registers of the core.

---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-controller signals between the pipeline datapath and the sequencer.
// master drives ID/EX status and requests; slave is the hazard controller itself.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [1:0]       id_rs_use_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_i;
  logic             ex_busy_i;
  logic             jump_req_i;
  logic [31:0]      jump_addr_i;
  logic             int_req_i;
  logic [31:0]      int_addr_i;
  logic [1:0]       hold_flag_o;
  logic             jump_flag_o;
  logic [31:0]      jump_addr_o;
  logic             int_ack_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs_use_i, ex_is_load_i, ex_rd_i, ex_busy_i,
           jump_req_i, jump_addr_i, int_req_i, int_addr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs_use_i, ex_is_load_i, ex_rd_i, ex_busy_i,
           jump_req_i, jump_addr_i, int_req_i, int_addr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, multi-cycle EX holds, redirect flushes
// and stall/flush perf counters.
//   state     | meaning
//   S_IDLE    | normal issue; evaluates interrupt/jump/busy/load-use
//   S_FLUSH   | holding PIPE_CLEAR for the remaining cycles of a redirect
//   S_WAIT_MC | EX multi-cycle op in progress; same decision logic as S_IDLE
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] HOLD_NONE  = 2'd0;
  localparam logic [1:0] HOLD_PC    = 2'd1;
  localparam logic [1:0] HOLD_IF    = 2'd2;
  localparam logic [1:0] PIPE_CLEAR = 2'd3;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_WAIT_MC = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        lu_hazard;
  logic [1:0]  hold_flag;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        int_ack;

  assign lu_hazard = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                     ((bus.id_rs_use_i[0] && (bus.id_rs1_i == bus.ex_rd_i)) ||
                      (bus.id_rs_use_i[1] && (bus.id_rs2_i == bus.ex_rd_i)));

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    hold_flag = HOLD_NONE;
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    int_ack   = 1'b0;

    case (state_q)
      S_FLUSH: begin
        hold_flag = PIPE_CLEAR;
        if (fcnt_q <= 3'd1) state_d = S_IDLE;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      default: begin
        // WAIT_MC shares this path: a still-busy EX keeps HOLD_IF, a jump still wins
        if (bus.int_req_i && !bus.ex_busy_i) begin
          jump_flag = 1'b1;
          jump_addr = bus.int_addr_i;
          int_ack   = 1'b1;
          hold_flag = PIPE_CLEAR;
          state_d   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
          fcnt_d    = FLUSH_LOAD;
        end else if (bus.jump_req_i) begin
          jump_flag = 1'b1;
          jump_addr = bus.jump_addr_i;
          hold_flag = PIPE_CLEAR;
          state_d   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
          fcnt_d    = FLUSH_LOAD;
        end else if (bus.ex_busy_i) begin
          hold_flag = HOLD_IF;
          state_d   = S_WAIT_MC;
        end else begin
          state_d = S_IDLE;
          if (lu_hazard) hold_flag = HOLD_IF;
        end
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((hold_flag == HOLD_PC || hold_flag == HOLD_IF) && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hold_flag == PIPE_CLEAR && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.hold_flag_o = hold_flag;
  assign bus.jump_flag_o = jump_flag;
  assign bus.jump_addr_o = jump_addr;
  assign bus.int_ack_o   = int_ack;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; a second small instance covers counter
// saturation and a longer flush.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus1 ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  bus2 ();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );
  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(3)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .bus(bus2)
  );

  typedef struct {
    logic [1:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic        ack;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle1();
    bus1.id_rs1_i = 0; bus1.id_rs2_i = 0; bus1.id_rs_use_i = 0;
    bus1.ex_is_load_i = 0; bus1.ex_rd_i = 0; bus1.ex_busy_i = 0;
    bus1.jump_req_i = 0; bus1.jump_addr_i = 0; bus1.int_req_i = 0; bus1.int_addr_i = 0;
  endtask

  task automatic idle2();
    bus2.id_rs1_i = 0; bus2.id_rs2_i = 0; bus2.id_rs_use_i = 0;
    bus2.ex_is_load_i = 0; bus2.ex_rd_i = 0; bus2.ex_busy_i = 0;
    bus2.jump_req_i = 0; bus2.jump_addr_i = 0; bus2.int_req_i = 0; bus2.int_addr_i = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1; idle1();
  endtask

  task automatic nxt2();
    @(posedge clk); #1; idle2();
  endtask

  // Counters show the sum of all earlier cycles' holds, so snapshot before adding this one.
  task automatic push(input logic [1:0] hold, input logic jf, input logic [31:0] ja, input logic ack);
    exp_t e;
    e.hold = hold; e.jf = jf; e.ja = ja; e.ack = ack;
    e.stall = m_stall; e.flush = m_flush;
    sb_q.push_back(e);
    if (hold == 2'd1 || hold == 2'd2) m_stall++;
    if (hold == 2'd3) m_flush++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("hold_flag", 32'(bus1.hold_flag_o), 32'(mon_e.hold));
      chk("jump_flag", 32'(bus1.jump_flag_o), 32'(mon_e.jf));
      chk("jump_addr", bus1.jump_addr_o, mon_e.ja);
      chk("int_ack",   32'(bus1.int_ack_o), 32'(mon_e.ack));
      chk("stall_cnt", bus1.stall_cnt_o, mon_e.stall);
      chk("flush_cnt", bus1.flush_cnt_o, mon_e.flush);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle1(); idle2();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    nxt(); rst = 1'b0; push(0, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);

    // load-use on rs1
    nxt(); bus1.ex_is_load_i = 1; bus1.ex_rd_i = 5; bus1.id_rs_use_i = 2'b01; bus1.id_rs1_i = 5;
    push(2, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);
    // load-use on rs2
    nxt(); bus1.ex_is_load_i = 1; bus1.ex_rd_i = 7; bus1.id_rs_use_i = 2'b10; bus1.id_rs2_i = 7;
    push(2, 0, 0, 0);
    // matching rd but not a load
    nxt(); bus1.ex_rd_i = 7; bus1.id_rs_use_i = 2'b01; bus1.id_rs1_i = 7;
    push(0, 0, 0, 0);
    // load with matching rs1 but rs1 not used
    nxt(); bus1.ex_is_load_i = 1; bus1.ex_rd_i = 7; bus1.id_rs_use_i = 2'b10; bus1.id_rs1_i = 7;
    bus1.id_rs2_i = 3;
    push(0, 0, 0, 0);
    // load to x0
    nxt(); bus1.ex_is_load_i = 1; bus1.ex_rd_i = 0; bus1.id_rs_use_i = 2'b01; bus1.id_rs1_i = 0;
    push(0, 0, 0, 0);

    // taken jump, FLUSH_CYCLES=2
    nxt(); bus1.jump_req_i = 1; bus1.jump_addr_i = 32'h100; push(3, 1, 32'h100, 0);
    nxt(); push(3, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);

    // 33 busy cycles with a coincident load-use
    for (int i = 0; i < 33; i++) begin
      nxt(); bus1.ex_busy_i = 1;
      bus1.ex_is_load_i = 1; bus1.ex_rd_i = 9; bus1.id_rs_use_i = 2'b01; bus1.id_rs1_i = 9;
      push(2, 0, 0, 0);
    end
    nxt(); push(0, 0, 0, 0);

    // interrupt blocked by busy, taken once busy drops
    for (int i = 0; i < 5; i++) begin
      nxt(); bus1.ex_busy_i = 1; bus1.int_req_i = 1; bus1.int_addr_i = 32'h8000_0040;
      push(2, 0, 0, 0);
    end
    nxt(); bus1.int_req_i = 1; bus1.int_addr_i = 32'h8000_0040; push(3, 1, 32'h8000_0040, 1);
    nxt(); push(3, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);

    // jump and busy together: jump wins, load-use discarded
    nxt(); bus1.jump_req_i = 1; bus1.jump_addr_i = 32'h200; bus1.ex_busy_i = 1;
    bus1.ex_is_load_i = 1; bus1.ex_rd_i = 4; bus1.id_rs_use_i = 2'b01; bus1.id_rs1_i = 4;
    push(3, 1, 32'h200, 0);
    nxt(); push(3, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);

    // interrupt arriving during FLUSH is held off until IDLE
    nxt(); bus1.jump_req_i = 1; bus1.jump_addr_i = 32'h440; push(3, 1, 32'h440, 0);
    nxt(); bus1.int_req_i = 1; bus1.int_addr_i = 32'h0000_0010; push(3, 0, 0, 0);
    nxt(); bus1.int_req_i = 1; bus1.int_addr_i = 32'h0000_0010; push(3, 1, 32'h10, 1);
    nxt(); push(3, 0, 0, 0);
    // interrupt beats a jump in the same cycle
    nxt(); bus1.int_req_i = 1; bus1.int_addr_i = 32'h0000_0020;
    bus1.jump_req_i = 1; bus1.jump_addr_i = 32'h500;
    push(3, 1, 32'h20, 1);
    nxt(); push(3, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);

    // reset in the FLUSH cycle drops everything
    nxt(); bus1.jump_req_i = 1; bus1.jump_addr_i = 32'h300; push(3, 1, 32'h300, 0);
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; m_stall = 0; m_flush = 0; push(0, 0, 0, 0);
    nxt(); push(0, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    // saturation instance: CNT_W=3, FLUSH_CYCLES=3
    for (int i = 0; i < 10; i++) begin
      nxt2(); bus2.ex_busy_i = 1;
    end
    nxt2();
    @(negedge clk);
    chk("sat_hold_after_busy", 32'(bus2.hold_flag_o), 32'd0);
    chk("sat_stall_cnt", 32'(bus2.stall_cnt_o), 32'd7);

    nxt2(); bus2.jump_req_i = 1; bus2.jump_addr_i = 32'h40;
    @(negedge clk);
    chk("f3_c0_hold", 32'(bus2.hold_flag_o), 32'd3);
    chk("f3_c0_jf",   32'(bus2.jump_flag_o), 32'd1);
    chk("f3_c0_addr", bus2.jump_addr_o, 32'h40);
    nxt2();
    @(negedge clk);
    chk("f3_c1_hold", 32'(bus2.hold_flag_o), 32'd3);
    chk("f3_c1_jf",   32'(bus2.jump_flag_o), 32'd0);
    nxt2();
    @(negedge clk);
    chk("f3_c2_hold", 32'(bus2.hold_flag_o), 32'd3);
    nxt2();
    @(negedge clk);
    chk("f3_c3_hold", 32'(bus2.hold_flag_o), 32'd0);
    chk("f3_flush_cnt", 32'(bus2.flush_cnt_o), 32'd3);

    for (int j = 0; j < 2; j++) begin
      nxt2(); bus2.jump_req_i = 1; bus2.jump_addr_i = 32'h80;
      repeat (3) nxt2();
    end
    @(negedge clk);
    chk("sat_flush_cnt", 32'(bus2.flush_cnt_o), 32'd7);
    chk("sat_stall_hold", 32'(bus2.stall_cnt_o), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
